wb_cmd_master: RTL and testbench

- Wishbone classic single-transfer initiator: the bus-master end of the slave interface exposed by the user project.
- Accepts one read/write command over a valid/ready command port and runs one Wishbone cycle per command.
- Returns read data, or a timeout error, over a valid/ready response port.
- Used on-chip to drive user-area Wishbone peripherals from a local controller, e.g. a logic-analyzer or IO command decoder.

---
 rtl/wb_cmd_master.sv | 130 +++++++++++++
 tb/tb_wb_cmd_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator.
// Takes one read/write command over a valid/ready port, runs one Wishbone
// cycle for it, and returns read data or a timeout error over a valid/ready
// response port. Only one transaction is ever outstanding.
module wb_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // command port
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  // response port
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            busy,
  // Wishbone master side
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter value seen in the last permitted strobe cycle. Only meaningful
  // when TIMEOUT is non-zero; the wrap for TIMEOUT=0 is masked below.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic            r_cyc;
  logic            r_we;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_dat;
  logic [DW/8-1:0] r_sel;
  logic [TW-1:0]   r_cnt;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_dat;
  logic            r_rsp_err;
  logic            w_timeout_hit;

  // Abort when the counter reaches the last allowed strobe cycle; an ack in
  // that same cycle is checked first and therefore wins.
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = r_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;

  // Command / bus / response state machine; reset drops any in-flight cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_we    <= cmd_we;
            r_adr   <= cmd_adr;
            r_dat   <= cmd_dat;
            r_sel   <= cmd_sel;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout_hit) begin
            r_cyc       <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_cyc   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed commands against a programmable slave,
// with responses checked by a scoreboard monitor.
module tb_wb_cmd_master;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  // slave model controls
  logic        ack_en, ack_force;
  int          ack_wait;
  int          wait_cnt;
  logic [31:0] slv_dat;

  int   n_pass  = 0;
  int   n_total = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(16), .TW(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  // Slave: acks combinationally once strobe has been high for ack_wait cycles.
  always @(posedge clk) wait_cnt <= wbm_stb_o ? wait_cnt + 1 : 0;
  assign wbm_ack_i = ack_force | (ack_en & wbm_stb_o & (wait_cnt == ack_wait));
  assign wbm_dat_i = slv_dat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: on every response handshake, pop the expected response.
  always begin
    @(negedge clk);
    #1;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_dat), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // Issue one command from a negedge; returns at the negedge where rsp_valid is first seen.
  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp_dat,
                         input logic exp_err, input int exp_stb);
    rsp_t e;
    int   t;
    int   n;
    logic rdy_low;
    e.dat = exp_dat;
    e.err = exp_err;
    exp_q.push_back(e);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    check("cmd_accept_bound", 64'(t < 100), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bus_adr", 64'(wbm_adr_o), 64'(adr));
    check("bus_we",  64'(wbm_we_o),  64'(we));
    check("bus_dat", 64'(wbm_dat_o), 64'(dat));
    check("bus_sel", 64'(wbm_sel_o), 64'(sel));
    check("bus_cyc", 64'(wbm_cyc_o), 64'd1);
    n = 0; rdy_low = 1'b1; t = 0;
    while (!rsp_valid && t < 100) begin
      if (wbm_stb_o) n++;
      if (cmd_ready) rdy_low = 1'b0;
      @(negedge clk);
      t++;
    end
    check("rsp_bound", 64'(t < 100), 64'd1);
    check("stb_cycles", 64'(n), 64'(exp_stb));
    check("cmd_ready_low", 64'(rdy_low), 64'd1);
    check("cyc_after", 64'(wbm_cyc_o), 64'd0);
    check("stb_after", 64'(wbm_stb_o), 64'd0);
  endtask

  initial begin
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b1; ack_en = 1'b1; ack_force = 1'b0; ack_wait = 0;
    slv_dat = '0;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    check("rst_stb", 64'(wbm_stb_o), 64'd0);
    check("rst_we",  64'(wbm_we_o),  64'd0);
    check("rst_adr", 64'(wbm_adr_o), 64'd0);
    check("rst_dat", 64'(wbm_dat_o), 64'd0);
    check("rst_sel", 64'(wbm_sel_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    wb_rst_i = 1'b0;
    @(negedge clk);

    // write, zero-wait slave
    ack_en = 1'b1; ack_wait = 0; slv_dat = 32'hDEAD_0000;
    run_cmd(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 1);
    @(negedge clk);
    check("wr_done_valid", 64'(rsp_valid), 64'd0);

    // read, 3 wait states
    ack_wait = 3; slv_dat = 32'h1234_5678;
    run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 4);
    @(negedge clk);

    // timeout, slave never acks
    ack_en = 1'b0;
    run_cmd(1'b0, 32'h3000_0030, 32'h0, 4'h3, 32'h0, 1'b1, 16);
    @(negedge clk);
    check("hold_adr", 64'(wbm_adr_o), 64'h3000_0030);
    check("hold_sel", 64'(wbm_sel_o), 64'h3);

    // ack in the last permitted strobe cycle
    ack_en = 1'b1; ack_wait = 15; slv_dat = 32'hCAFE_F00D;
    run_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 16);
    @(negedge clk);

    // response backpressure
    ack_wait = 0; slv_dat = 32'h1111_2222; rsp_ready = 1'b0;
    run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h1111_2222, 1'b0, 1);
    begin
      rsp_t e2;
      e2.dat = 32'h0; e2.err = 1'b0;
      exp_q.push_back(e2);
    end
    cmd_we = 1'b1; cmd_adr = 32'h3000_0008; cmd_dat = 32'hA5A5_0002; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_dat", 64'(rsp_dat), 64'h1111_2222);
      check("bp_err", 64'(rsp_err), 64'd0);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp_cyc", 64'(wbm_cyc_o), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 64'(rsp_valid), 64'd0);
    check("bp_hs_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_next_busy", 64'(busy), 64'd1);
    check("bp_next_cyc", 64'(wbm_cyc_o), 64'd1);
    check("bp_next_we", 64'(wbm_we_o), 64'd1);
    check("bp_next_adr", 64'(wbm_adr_o), 64'h3000_0008);
    @(negedge clk);
    check("bp_next_rsp", 64'(rsp_valid), 64'd1);
    @(negedge clk);

    // reset during BUS at wait state 2
    ack_wait = 5;
    cmd_we = 1'b0; cmd_adr = 32'h3000_0050; cmd_dat = 32'h0; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_pre_cyc", 64'(wbm_cyc_o), 64'd1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check("rstmid_cyc", 64'(wbm_cyc_o), 64'd0);
    check("rstmid_stb", 64'(wbm_stb_o), 64'd0);
    check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstmid_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rstmid_adr", 64'(wbm_adr_o), 64'd0);
    wb_rst_i = 1'b0;
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_ack_busy", 64'(busy), 64'd0);
    check("stray_ack_valid", 64'(rsp_valid), 64'd0);
    check("stray_ack_cyc", 64'(wbm_cyc_o), 64'd0);
    ack_force = 1'b0;
    ack_wait = 0; slv_dat = 32'h0BAD_BEEF;
    run_cmd(1'b0, 32'h3000_0060, 32'h0, 4'hC, 32'h0BAD_BEEF, 1'b0, 1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
